fadd_norm_round: RTL and testbench

Final stage of the pipelined single-precision FP adder. It consumes the aligned sum fields captured by the align-to-normalize pipeline register, then normalizes, rounds, and handles overflow, underflow and inf/NaN. It delivers a registered 32-bit IEEE-754 result with status flags. It also drives the enable `e` of the upstream pipeline register, so downstream back-pressure stalls the adder pipeline.

---
 rtl/fadd_norm_round.sv | 133 +++++++++++++
 tb/tb_fadd_norm_round.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fadd_norm_round.sv
// Final FP adder stage: normalizes and rounds the aligned sum, resolves overflow/inf/NaN,
// and registers the IEEE-754 single result with status flags behind a valid/ready output.
module fadd_norm_round (
  input  logic        clock,
  input  logic        clrn,
  input  logic [1:0]  n_rm,
  input  logic        n_sign,
  input  logic [9:0]  n_exp10,
  input  logic        n_is_inf_nan,
  input  logic [22:0] n_inf_nan_frac,
  input  logic [27:0] n_frac,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        e,
  output logic [31:0] s,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_inexact,
  output logic        out_valid,
  input  logic        out_ready
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // in_ready is high when the output slot is empty or is being drained this cycle;
  // e mirrors it so the upstream register freezes exactly when this stage stalls.
  logic capture;
  assign in_ready = ~out_valid | out_ready;
  assign e        = in_ready;
  assign capture  = in_valid & in_ready;

  // Leading-zero count of the sum below the carry bit; the highest set bit wins.
  logic [4:0] lz;
  always_comb begin
    lz = 5'd26;
    for (int i = 0; i < 27; i++) begin
      if (n_frac[i]) lz = 5'(26 - i);
    end
  end

  logic [4:0]  sh;
  logic [26:0] nf;
  logic [9:0]  ne;
  always_comb begin
    sh = lz;
    nf = n_frac[26:0];
    ne = n_exp10;
    if (n_frac[27]) begin
      nf = {n_frac[27:2], n_frac[1] | n_frac[0]};
      ne = n_exp10 + 10'd1;
    end else if (n_exp10 > {5'd0, lz}) begin
      nf = n_frac[26:0] << sh;
      ne = n_exp10 - {5'd0, lz};
    end else begin
      // Exponent runs out before the leading one reaches the hidden bit: denormal.
      sh = n_exp10[4:0] - 5'd1;
      nf = n_frac[26:0] << sh;
      ne = '0;
    end
  end

  logic        grs_nz;
  logic        inc;
  logic [24:0] mant25;
  logic [22:0] frac_r;
  logic [9:0]  exp_r;
  logic        ovf;
  logic        to_inf;
  always_comb begin
    grs_nz = |nf[2:0];
    case (n_rm)
      2'b00:   inc = nf[2] & (nf[1] | nf[0] | nf[3]);
      2'b01:   inc = n_sign & grs_nz;
      2'b10:   inc = ~n_sign & grs_nz;
      default: inc = 1'b0;
    endcase
    mant25 = {1'b0, nf[26:3]} + {24'd0, inc};
    if (mant25[24]) begin
      frac_r = mant25[23:1];
      exp_r  = ne + 10'd1;
    end else begin
      frac_r = mant25[22:0];
      exp_r  = (ne == 10'd0 && mant25[23]) ? 10'd1 : ne;
    end
    ovf = (exp_r >= 10'd255);
    case (n_rm)
      2'b00:   to_inf = 1'b1;
      2'b01:   to_inf = n_sign;
      2'b10:   to_inf = ~n_sign;
      default: to_inf = 1'b0;
    endcase
  end

  logic [31:0] s_nxt;
  logic        ovf_nxt;
  logic        unf_nxt;
  logic        inx_nxt;
  always_comb begin
    s_nxt   = {n_sign, exp_r[7:0], frac_r};
    ovf_nxt = 1'b0;
    inx_nxt = grs_nz;
    if (n_is_inf_nan) begin
      s_nxt   = {n_sign, 8'hFF, n_inf_nan_frac};
      inx_nxt = 1'b0;
    end else if (n_frac == 28'd0) begin
      s_nxt   = {n_sign, 31'd0};
      inx_nxt = 1'b0;
    end else if (ovf) begin
      s_nxt   = to_inf ? {n_sign, 8'hFF, 23'd0} : {n_sign, 8'hFE, 23'h7FFFFF};
      ovf_nxt = 1'b1;
      inx_nxt = 1'b1;
    end
    unf_nxt = ~n_is_inf_nan & (ne == 10'd0) & inx_nxt;
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      out_valid      <= 1'b0;
      s              <= '0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
    end else if (capture) begin
      out_valid      <= 1'b1;
      s              <= s_nxt;
      flag_overflow  <= ovf_nxt;
      flag_underflow <= unf_nxt;
      flag_inexact   <= inx_nxt;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fadd_norm_round.sv
// Bench for fadd_norm_round: vector table through a scoreboard under random back-pressure,
// then hand-written stall and mid-stall reset sequences.
module tb_fadd_norm_round;

  logic        clock = 1'b0;
  logic        clrn = 1'b0;
  logic [1:0]  n_rm = '0;
  logic        n_sign = 1'b0;
  logic [9:0]  n_exp10 = '0;
  logic        n_is_inf_nan = 1'b0;
  logic [22:0] n_inf_nan_frac = '0;
  logic [27:0] n_frac = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        e;
  logic [31:0] s;
  logic        flag_overflow;
  logic        flag_underflow;
  logic        flag_inexact;
  logic        out_valid;
  logic        out_ready = 1'b1;

  fadd_norm_round dut (
    .clock(clock), .clrn(clrn), .n_rm(n_rm), .n_sign(n_sign), .n_exp10(n_exp10),
    .n_is_inf_nan(n_is_inf_nan), .n_inf_nan_frac(n_inf_nan_frac), .n_frac(n_frac),
    .in_valid(in_valid), .in_ready(in_ready), .e(e), .s(s),
    .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
    .flag_inexact(flag_inexact), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  rm;
    logic        sign;
    logic [9:0]  exp;
    logic        inf;
    logic [22:0] inf_frac;
    logic [27:0] frac;
    logic [31:0] s;
    logic [2:0]  fl;   // {overflow, underflow, inexact}
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];
  logic [34:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  bit rand_bp = 1'b0;

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clock) if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);

  // Scoreboard: an output is consumed on the edge after a cycle showing valid & ready.
  always begin
    @(negedge clock);
    #2;
    if (clrn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h, expected none", {s, flag_overflow, flag_underflow, flag_inexact});
      end else begin
        check("result", {s, flag_overflow, flag_underflow, flag_inexact}, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input vec_t v);
    n_rm = v.rm;
    n_sign = v.sign;
    n_exp10 = v.exp;
    n_is_inf_nan = v.inf;
    n_inf_nan_frac = v.inf_frac;
    n_frac = v.frac;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int budget;
    @(negedge clock);
    drive(v);
    budget = 0;
    #1;
    while (!in_ready && budget < 50) begin
      @(negedge clock);
      #1;
      budget++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready %0b, expected 1", in_ready);
    end else begin
      exp_q.push_back({v.s, v.fl});
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(negedge clock);
      b++;
    end
    @(negedge clock);
    check("drain_pending", 35'(exp_q.size()), 35'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 1'b0, 10'd127, 1'b0, 23'd0, 28'h8000000, 32'h40000000, 3'b000};
    vecs[1]  = '{2'b00, 1'b0, 10'd127, 1'b0, 23'd0, 28'h400000C, 32'h3F800002, 3'b001};
    vecs[2]  = '{2'b11, 1'b0, 10'd127, 1'b0, 23'd0, 28'h400000C, 32'h3F800001, 3'b001};
    vecs[3]  = '{2'b00, 1'b0, 10'd254, 1'b0, 23'd0, 28'h8000000, 32'h7F800000, 3'b101};
    vecs[4]  = '{2'b11, 1'b0, 10'd254, 1'b0, 23'd0, 28'h8000000, 32'h7F7FFFFF, 3'b101};
    vecs[5]  = '{2'b01, 1'b0, 10'd254, 1'b0, 23'd0, 28'h8000000, 32'h7F7FFFFF, 3'b101};
    vecs[6]  = '{2'b01, 1'b1, 10'd254, 1'b0, 23'd0, 28'h8000000, 32'hFF800000, 3'b101};
    vecs[7]  = '{2'b10, 1'b1, 10'd254, 1'b0, 23'd0, 28'h8000000, 32'hFF7FFFFF, 3'b101};
    vecs[8]  = '{2'b10, 1'b0, 10'd254, 1'b0, 23'd0, 28'h8000000, 32'h7F800000, 3'b101};
    vecs[9]  = '{2'b00, 1'b0, 10'd1,   1'b0, 23'd0, 28'h0000008, 32'h00000001, 3'b000};
    vecs[10] = '{2'b10, 1'b0, 10'd1,   1'b0, 23'd0, 28'h0000009, 32'h00000002, 3'b011};
    vecs[11] = '{2'b00, 1'b0, 10'd0,   1'b1, 23'h400000, 28'h0000000, 32'h7FC00000, 3'b000};
    vecs[12] = '{2'b00, 1'b1, 10'd0,   1'b1, 23'h000000, 28'h1234567, 32'hFF800000, 3'b000};
    vecs[13] = '{2'b00, 1'b1, 10'd100, 1'b0, 23'd0, 28'h0000000, 32'h80000000, 3'b000};
    vecs[14] = '{2'b00, 1'b0, 10'd127, 1'b0, 23'd0, 28'h1000000, 32'h3E800000, 3'b000};
    vecs[15] = '{2'b00, 1'b0, 10'd3,   1'b0, 23'd0, 28'h0400000, 32'h00200000, 3'b000};
    vecs[16] = '{2'b00, 1'b0, 10'd127, 1'b0, 23'd0, 28'h7FFFFFC, 32'h40000000, 3'b001};
    vecs[17] = '{2'b00, 1'b0, 10'd127, 1'b0, 23'd0, 28'h4000004, 32'h3F800000, 3'b001};
    vecs[18] = '{2'b00, 1'b0, 10'd1,   1'b0, 23'd0, 28'h3FFFFFC, 32'h00800000, 3'b011};
    vecs[19] = '{2'b10, 1'b0, 10'd127, 1'b0, 23'd0, 28'h8000003, 32'h40000001, 3'b001};
    vecs[20] = '{2'b01, 1'b1, 10'd127, 1'b0, 23'd0, 28'h4000001, 32'hBF800001, 3'b001};

    #1;
    check("reset_out_valid", 35'(out_valid), 35'd0);
    check("reset_s_flags", {s, flag_overflow, flag_underflow, flag_inexact}, 35'd0);
    check("reset_ready_e", 35'({in_ready, e}), 35'b11);
    repeat (2) @(negedge clock);
    clrn = 1'b1;

    rand_bp = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(vecs[i]);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    @(negedge clock);
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    // Stall: output held, next input waits until the consumer accepts.
    @(negedge clock);
    out_ready = 1'b0;
    send(vecs[1]);
    @(negedge clock);
    drive(vecs[3]);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_s", 35'(s), 35'(vecs[1].s));
      check("stall_valid_ready_e", 35'({out_valid, in_ready, e}), 35'b100);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", 35'({in_ready, e}), 35'b11);
    exp_q.push_back({vecs[3].s, vecs[3].fl});
    @(posedge clock);
    #1 in_valid = 1'b0;
    drain();

    // Reset in the middle of a stall.
    @(negedge clock);
    out_ready = 1'b0;
    send(vecs[2]);
    @(negedge clock);
    #1;
    check("prereset_s", 35'(s), 35'(vecs[2].s));
    #2 clrn = 1'b0;
    #1;
    check("midstall_reset_valid", 35'(out_valid), 35'd0);
    check("midstall_reset_s_flags", {s, flag_overflow, flag_underflow, flag_inexact}, 35'd0);
    check("midstall_reset_ready_e", 35'({in_ready, e}), 35'b11);
    exp_q.delete();
    @(negedge clock);
    clrn = 1'b1;
    out_ready = 1'b1;
    send(vecs[10]);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
